ram_stream_reader: RTL and testbench

Initiator-side controller for the single-port synchronous `ram` block. On a start command it reads `len` consecutive words beginning at `start_addr`, accounting for the RAM's registered-address read latency. It delivers the words in order on a valid/ready output stream with full backpressure support. It sits between a RAM instance and any downstream consumer (display, UART TX, checker) that needs a memory image streamed out.

---
 rtl/ram_stream_reader_if.sv | 32 +++
 rtl/ram_stream_reader.sv | 130 +++++++++++++
 tb/tb_ram_stream_reader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_if.sv
// Bundle of the command, RAM-side and stream-side signals of ram_stream_reader.
// "master" is the reader's view, "slave" is the view of the surrounding logic.
interface ram_stream_reader_if #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 3
);
    // Command / status
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH:0]   len;
    logic                  busy;
    logic                  done;
    // RAM port
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_q;
    // Output stream
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  start, start_addr, len, ram_q, out_ready,
        output busy, done, ram_addr, ram_we, ram_wdata, out_data, out_valid
    );

    modport slave (
        output start, start_addr, len, ram_q, out_ready,
        input  busy, done, ram_addr, ram_we, ram_wdata, out_data, out_valid
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Streams len consecutive words out of a single-port synchronous RAM.
// Reads are issued one per cycle while the 2-entry output FIFO plus the
// read in flight leave room, so the stream runs at full rate and stalls
// cleanly under backpressure without ever overflowing the FIFO.
module ram_stream_reader #(
    parameter int DATA_WIDTH = 3,
    parameter int ADDR_WIDTH = 3
) (
    input logic               clk,
    input logic               rst,
    ram_stream_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic                  inflight_q;
    logic                  busy_q;
    logic                  done_q;

    // FIFO: head_q is the stream output register, tail_q the second slot
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            occupancy;

    assign pop       = (count_q != 2'd0) && bus.out_ready;
    assign push      = inflight_q;
    // Words that will be held after this cycle's pop, counting the read in flight
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == RUN) && (occupancy < 3'd2);

    // Between issues the address bus parks on the last issued address
    assign bus.ram_addr  = issue ? ptr_q : addr_q;
    assign bus.ram_we    = 1'b0;
    assign bus.ram_wdata = '0;
    assign bus.out_data  = head_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    // FIFO next state: pop shifts the tail into the head, then the returning word is appended
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
        end
        if (push) begin
            if (count_d == 2'd0) begin
                head_d = bus.ram_q;
            end else begin
                tail_d = bus.ram_q;
            end
            count_d = count_d + 2'd1;
        end
    end

    // Control FSM with registered busy/done, read-issue bookkeeping and FIFO storage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= issue;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.len != '0) begin
                            ptr_q   <= bus.start_addr;
                            cnt_q   <= bus.len;
                            state_q <= RUN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_q <= ptr_q;
                        ptr_q  <= ptr_q + ADDR_WIDTH'(1);
                        cnt_q  <= cnt_q - (ADDR_WIDTH + 1)'(1);
                        if (cnt_q == (ADDR_WIDTH + 1)'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Finish once nothing is in flight and the last word leaves this cycle
                    if (!inflight_q && (count_d == 2'd0)) begin
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A returning word must always find a free FIFO slot
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == 2'd2)));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: behavioural RAM, random contents
// and backpressure, expected words computed directly from address arithmetic.
module tb_ram_stream_reader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_stream_reader_if #(.DATA_WIDTH(3), .ADDR_WIDTH(3)) bus ();

    ram_stream_reader #(.DATA_WIDTH(3), .ADDR_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous RAM with registered address read
    logic [2:0] mem [0:7];
    always_ff @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

    int checks = 0;
    int failures = 0;

    logic [2:0] got_q[$];
    logic [2:0] exp_q[$];
    int first_cyc, last_cyc, done_cyc, stab_err, vld_idle, busy_c1;

    function automatic void build_exp(input logic [2:0] sa, input logic [3:0] ln);
        exp_q.delete();
        for (int k = 0; k < int'(ln); k++) exp_q.push_back(mem[(int'(sa) + k) % 8]);
    endfunction

    function automatic void fill_random();
        for (int i = 0; i < 8; i++) mem[i] = 3'($urandom_range(7));
    endfunction

    // Runs one command from cycle 0 (caller sits just after a posedge) and records the stream.
    // Returns just after the posedge that ends the done cycle.
    task automatic run_cmd(input logic [2:0] sa, input logic [3:0] ln, input int rdy_pct,
                           input int extra_cyc);
        logic       pv;
        logic [2:0] pd;
        got_q.delete();
        first_cyc = -1; last_cyc = -1; done_cyc = -1;
        stab_err = 0; vld_idle = 0; busy_c1 = 0;
        pv = 1'b0; pd = 3'd0;
        bus.start = 1'b1; bus.start_addr = sa; bus.len = ln;
        bus.out_ready = (rdy_pct >= 100) || (int'($urandom_range(99)) < rdy_pct);
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                bus.start = (cyc == extra_cyc);
                if (cyc == extra_cyc) begin
                    bus.start_addr = 3'd0;
                    bus.len = 4'd3;
                end
                bus.out_ready = (rdy_pct >= 100) || (int'($urandom_range(99)) < rdy_pct);
            end
            @(negedge clk);
            if (cyc == 1) busy_c1 = int'(bus.busy);
            if (pv && !(bus.out_valid && bus.out_data == pd)) stab_err++;
            if (bus.out_valid && !bus.busy) vld_idle++;
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(bus.out_data);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            pv = bus.out_valid && !bus.out_ready;
            pd = bus.out_data;
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.out_data !== 3'd0) begin failures++; $display("FAIL reset_data got=%0d want=0", bus.out_data); end
        checks++; if (bus.ram_addr !== 3'd0) begin failures++; $display("FAIL reset_addr got=%0d want=0", bus.ram_addr); end
        checks++; if (bus.ram_we !== 1'b0 || bus.ram_wdata !== 3'd0) begin
            failures++; $display("FAIL reset_we got we=%b wdata=%0d want 0/0", bus.ram_we, bus.ram_wdata); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) mem[i] = 3'(i);
        build_exp(3'd2, 4'd4);
        run_cmd(3'd2, 4'd4, 100, -1);
        checks++; if (got_q.size() != 4) begin failures++; $display("FAIL basic_count got=%0d want=4", got_q.size()); end
        for (int k = 0; k < 4; k++) begin
            logic [2:0] g;
            g = (k < got_q.size()) ? got_q[k] : 3'bxxx;
            checks++; if (g !== exp_q[k]) begin failures++; $display("FAIL basic_word%0d got=%0d want=%0d", k, g, exp_q[k]); end
        end
        checks++; if (first_cyc != 3) begin failures++; $display("FAIL basic_first_cycle got=%0d want=3", first_cyc); end
        checks++; if (last_cyc != 6) begin failures++; $display("FAIL basic_last_cycle got=%0d want=6", last_cyc); end
        checks++; if (done_cyc != 7) begin failures++; $display("FAIL basic_done_cycle got=%0d want=7", done_cyc); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_wrap();
        logic [2:0] sas [2] = '{3'd6, 3'd5};
        logic [3:0] lns [2] = '{4'd4, 4'd8};
        fill_random();
        for (int t = 0; t < 2; t++) begin
            build_exp(sas[t], lns[t]);
            run_cmd(sas[t], lns[t], 100, -1);
            checks++; if (got_q.size() != exp_q.size()) begin
                failures++; $display("FAIL wrap%0d_count got=%0d want=%0d", t, got_q.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size(); k++) begin
                logic [2:0] g;
                g = (k < got_q.size()) ? got_q[k] : 3'bxxx;
                checks++; if (g !== exp_q[k]) begin failures++; $display("FAIL wrap%0d_word%0d got=%0d want=%0d", t, k, g, exp_q[k]); end
            end
            checks++; if (done_cyc != int'(lns[t]) + 3) begin
                failures++; $display("FAIL wrap%0d_done_cycle got=%0d want=%0d", t, done_cyc, int'(lns[t]) + 3); end
        end
    endtask

    task automatic test_backpressure();
        for (int t = 0; t < 6; t++) begin
            logic [2:0] sa;
            logic [3:0] ln;
            fill_random();
            sa = 3'($urandom_range(7));
            ln = (t < 3) ? 4'd8 : 4'($urandom_range(8, 1));
            build_exp(sa, ln);
            run_cmd(sa, ln, 50, -1);
            checks++; if (done_cyc < 0) begin failures++; $display("FAIL bp%0d_timeout got=no_done want=done", t); end
            checks++; if (got_q.size() != exp_q.size()) begin
                failures++; $display("FAIL bp%0d_count got=%0d want=%0d", t, got_q.size(), exp_q.size()); end
            for (int k = 0; k < exp_q.size(); k++) begin
                logic [2:0] g;
                g = (k < got_q.size()) ? got_q[k] : 3'bxxx;
                checks++; if (g !== exp_q[k]) begin failures++; $display("FAIL bp%0d_word%0d got=%0d want=%0d", t, k, g, exp_q[k]); end
            end
            checks++; if (stab_err != 0) begin failures++; $display("FAIL bp%0d_stable got=%0d want=0", t, stab_err); end
            checks++; if (vld_idle != 0) begin failures++; $display("FAIL bp%0d_valid_idle got=%0d want=0", t, vld_idle); end
        end
    endtask

    task automatic test_len0_busy_start();
        run_cmd(3'd4, 4'd0, 100, -1);
        checks++; if (busy_c1 != 1) begin failures++; $display("FAIL len0_busy got=%0d want=1", busy_c1); end
        checks++; if (done_cyc != 1) begin failures++; $display("FAIL len0_done_cycle got=%0d want=1", done_cyc); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL len0_words got=%0d want=0", got_q.size()); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL len0_idle got=%b want=0", bus.busy); end

        fill_random();
        build_exp(3'd3, 4'd5);
        run_cmd(3'd3, 4'd5, 100, 3);
        checks++; if (got_q.size() != 5) begin failures++; $display("FAIL busystart_count got=%0d want=5", got_q.size()); end
        for (int k = 0; k < 5; k++) begin
            logic [2:0] g;
            g = (k < got_q.size()) ? got_q[k] : 3'bxxx;
            checks++; if (g !== exp_q[k]) begin failures++; $display("FAIL busystart_word%0d got=%0d want=%0d", k, g, exp_q[k]); end
        end
        checks++; if (done_cyc != 8) begin failures++; $display("FAIL busystart_done_cycle got=%0d want=8", done_cyc); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] sa;
        fill_random();
        run_cmd(3'd1, 4'd3, 100, 6);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_start_in_done got=%b want=0", bus.busy); end
        sa = 3'($urandom_range(7));
        build_exp(sa, 4'd2);
        run_cmd(sa, 4'd2, 100, -1);
        checks++; if (first_cyc != 3) begin failures++; $display("FAIL b2b_first_cycle got=%0d want=3", first_cyc); end
        checks++; if (done_cyc != 5) begin failures++; $display("FAIL b2b_done_cycle got=%0d want=5", done_cyc); end
        for (int k = 0; k < 2; k++) begin
            logic [2:0] g;
            g = (k < got_q.size()) ? got_q[k] : 3'bxxx;
            checks++; if (g !== exp_q[k]) begin failures++; $display("FAIL b2b_word%0d got=%0d want=%0d", k, g, exp_q[k]); end
        end
    endtask

    task automatic test_reset_mid();
        int words;
        int cyc;
        fill_random();
        words = 0;
        cyc = 0;
        bus.start = 1'b1; bus.start_addr = 3'($urandom_range(7)); bus.len = 4'd6; bus.out_ready = 1'b1;
        while (words < 2 && cyc < 50) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) words++;
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
        end
        checks++; if (words != 2) begin failures++; $display("FAIL rstmid_words got=%0d want=2", words); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.ram_addr !== 3'd0) begin failures++; $display("FAIL rstmid_addr got=%0d want=0", bus.ram_addr); end
        build_exp(3'd1, 4'd2);
        run_cmd(3'd1, 4'd2, 100, -1);
        checks++; if (first_cyc != 3) begin failures++; $display("FAIL rstmid_first_cycle got=%0d want=3", first_cyc); end
        checks++; if (got_q.size() != 2) begin failures++; $display("FAIL rstmid_count got=%0d want=2", got_q.size()); end
        for (int k = 0; k < 2; k++) begin
            logic [2:0] g;
            g = (k < got_q.size()) ? got_q[k] : 3'bxxx;
            checks++; if (g !== exp_q[k]) begin failures++; $display("FAIL rstmid_word%0d got=%0d want=%0d", k, g, exp_q[k]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.start_addr = 3'd0;
        bus.len = 4'd0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = 3'd0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len0_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
